// File: rtl/i2s_tx.sv
// i2s_tx: frame-based I2S transmitter. A one-cycle rate strobe latches a
// left/right sample pair and sends one 64-slot frame. Each slot is one sclk
// period, and each sclk half-period is HDIV clk cycles. Data is sent MSB-first
// with the usual I2S one-slot delay after each lrck edge.
// Optional feature macro: I2S_TX_OVERRUN_EN adds a sticky 'overrun' output.
// It flags any rate strobe that arrives mid-frame and is therefore ignored.
//
// state | meaning
// IDLE  | no frame in progress, outputs held at 0
// RUN   | frame in progress, sclk toggling and slots advancing
module i2s_tx #(
  parameter int DW   = 16,
  parameter int HDIV = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rate,
  input  logic [DW-1:0] l_data,
  input  logic [DW-1:0] r_data,
  output logic          ready,
  output logic          sclk,
  output logic          lrck,
  output logic          sdata
`ifdef I2S_TX_OVERRUN_EN
  ,
  output logic          overrun
`endif
);

  localparam int HW  = (HDIV > 1) ? $clog2(HDIV) : 1;
  localparam int PAD = 32 - DW;
  localparam logic [HW-1:0] HMAX = HW'(HDIV - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   hcnt_q, hcnt_d;
  logic [5:0]      slot_q, slot_d;
  logic            sclk_q, sclk_d;
  logic            lrck_q, lrck_d;
  logic            sdata_q, sdata_d;
  logic            ready_q, ready_d;
  logic [DW-1:0]   l_q, l_d;
  logic [DW-1:0]   r_q, r_d;
  logic [31:0]     sh_q, sh_d;
`ifdef I2S_TX_OVERRUN_EN
  logic            ovr_q, ovr_d;
`endif

  logic            hwrap;
  logic            fall;
  logic            last;
  logic            accept;
  logic [5:0]      nslot;
  logic [31:0]     word;

  // Frame-timing decodes. 'last' is the final clk cycle of a frame, when a
  // new rate can chain the next frame without a gap.
  always_comb begin
    hwrap  = (hcnt_q == HMAX);
    fall   = hwrap & sclk_q;
    last   = (state_q == RUN) & fall & (slot_q == 6'd63);
    accept = rate & ((state_q == IDLE) | last);
    nslot  = slot_q + 6'd1;
  end

  // Next-state and datapath: start, advance, or end the frame.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    slot_d  = slot_q;
    sclk_d  = sclk_q;
    lrck_d  = lrck_q;
    sdata_d = sdata_q;
    ready_d = 1'b0;
    l_d     = l_q;
    r_d     = r_q;
    sh_d    = sh_q;
    word    = 32'd0;
`ifdef I2S_TX_OVERRUN_EN
    ovr_d   = ovr_q;
`endif

    if (accept) begin
      // Slot 0 is always a zero bit, so the shifter starts empty.
      state_d = RUN;
      l_d     = l_data;
      r_d     = r_data;
      ready_d = 1'b1;
      hcnt_d  = '0;
      slot_d  = 6'd0;
      sclk_d  = 1'b0;
      lrck_d  = 1'b0;
      sdata_d = 1'b0;
      sh_d    = 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        RUN: begin
`ifdef I2S_TX_OVERRUN_EN
          if (rate) ovr_d = 1'b1;
`endif
          if (last) begin
            state_d = IDLE;
            hcnt_d  = '0;
            slot_d  = 6'd0;
            sclk_d  = 1'b0;
            lrck_d  = 1'b0;
            sdata_d = 1'b0;
            sh_d    = 32'd0;
          end else if (hwrap) begin
            hcnt_d = '0;
            sclk_d = ~sclk_q;
            if (fall) begin
              // A sample is loaded one slot after each lrck edge and is padded
              // with zeros, so the slots after the sample shift out zeros.
              slot_d = nslot;
              lrck_d = nslot[5];
              if (nslot[4:0] == 5'd1) begin
                word    = nslot[5] ? {r_q, {PAD{1'b0}}} : {l_q, {PAD{1'b0}}};
                sdata_d = word[31];
                sh_d    = {word[30:0], 1'b0};
              end else begin
                sdata_d = sh_q[31];
                sh_d    = {sh_q[30:0], 1'b0};
              end
            end
          end else begin
            hcnt_d = hcnt_q + HW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers. Every output comes straight from a flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
      slot_q  <= 6'd0;
      sclk_q  <= 1'b0;
      lrck_q  <= 1'b0;
      sdata_q <= 1'b0;
      ready_q <= 1'b0;
      l_q     <= '0;
      r_q     <= '0;
      sh_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      slot_q  <= slot_d;
      sclk_q  <= sclk_d;
      lrck_q  <= lrck_d;
      sdata_q <= sdata_d;
      ready_q <= ready_d;
      l_q     <= l_d;
      r_q     <= r_d;
      sh_q    <= sh_d;
    end
  end

`ifdef I2S_TX_OVERRUN_EN
  // Sticky overrun flag. Only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ovr_q <= 1'b0;
    else        ovr_q <= ovr_d;
  end

  assign overrun = ovr_q;
`endif

  assign ready = ready_q;
  assign sclk  = sclk_q;
  assign lrck  = lrck_q;
  assign sdata = sdata_q;

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: directed bench for i2s_tx. One default instance (DW=16, HDIV=3)
// and one DW=24 instance share the clock, reset and rate inputs.
module tb_i2s_tx;

  localparam int HD    = 3;
  localparam int FRAME = 128 * HD;

  logic        clk;
  logic        reset;
  logic        rate;
  logic [15:0] l16, r16;
  logic [23:0] l24, r24;
  logic        ready16, sclk16, lrck16, sdata16;
  logic        ready24, sclk24, lrck24, sdata24;
`ifdef I2S_TX_OVERRUN_EN
  logic        ovr16, ovr24;
`endif
  logic        use24;
  logic        ready_s, sclk_s, lrck_s, sdata_s;

  int n_vec;
  int n_err;

  i2s_tx #(.DW(16), .HDIV(HD)) dut (
    .clk(clk), .reset(reset), .rate(rate), .l_data(l16), .r_data(r16),
    .ready(ready16), .sclk(sclk16), .lrck(lrck16), .sdata(sdata16)
`ifdef I2S_TX_OVERRUN_EN
    , .overrun(ovr16)
`endif
  );

  i2s_tx #(.DW(24), .HDIV(HD)) dut24 (
    .clk(clk), .reset(reset), .rate(rate), .l_data(l24), .r_data(r24),
    .ready(ready24), .sclk(sclk24), .lrck(lrck24), .sdata(sdata24)
`ifdef I2S_TX_OVERRUN_EN
    , .overrun(ovr24)
`endif
  );

  assign ready_s = use24 ? ready24 : ready16;
  assign sclk_s  = use24 ? sclk24  : sclk16;
  assign lrck_s  = use24 ? lrck24  : lrck16;
  assign sdata_s = use24 ? sdata24 : sdata16;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected slot vector for a DW=16 frame. Slot s sits at bit 63-s.
  function automatic logic [63:0] exp_vec16(input logic [15:0] l, input logic [15:0] r);
    return ({48'd0, l} << 47) | ({48'd0, r} << 15);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse rate for one cycle. On return the bench is in cycle t+1.
  task automatic start_frame();
    rate = 1'b1;
    step();
    rate = 1'b0;
  endtask

  // Observe frame cycles t+1..t+FRAME. Optionally drive rate in cycle t+rate_at
  // and load new data at the same time.
  task automatic capture(input int rate_at, input logic [15:0] nl, input logic [15:0] nr,
                         output logic [63:0] sd_v, output logic [63:0] lr_v,
                         output int sclk_err, output int chg_err, output int rdy_cnt,
                         output logic ovr100, output logic ovr101);
    logic ps, psd, plr;
    logic exp_s;
    int   slot;
    sd_v = '0; lr_v = '0; sclk_err = 0; chg_err = 0; rdy_cnt = 0;
    ovr100 = 1'b0; ovr101 = 1'b0;
    ps = 1'b0; psd = 1'b0; plr = 1'b0;
    for (int k = 1; k <= FRAME; k++) begin
      rate  = 1'b0;
      exp_s = (((k - 1) / HD) % 2) == 1;
      slot  = (k - 1) / (2 * HD);
      if (sclk_s !== exp_s) sclk_err++;
      if ((k - 1) % (2 * HD) == 0) begin
        sd_v[63 - slot] = sdata_s;
        lr_v[63 - slot] = lrck_s;
      end
      if (k > 1 && (sdata_s !== psd || lrck_s !== plr) && !(ps === 1'b1 && sclk_s === 1'b0))
        chg_err++;
      if (k > 1 && ready_s !== 1'b0) rdy_cnt++;
`ifdef I2S_TX_OVERRUN_EN
      if (k == 100) ovr100 = ovr16;
      if (k == 101) ovr101 = ovr16;
`endif
      ps = sclk_s; psd = sdata_s; plr = lrck_s;
      if (k == rate_at) begin
        rate = 1'b1;
        l16  = nl;
        r16  = nr;
      end
      step();
    end
    rate = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; rate = 1'b0; use24 = 1'b0;
    l16 = '0; r16 = '0; l24 = '0; r24 = '0;
    repeat (3) step();
    n_vec++; if (ready16 !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b expected 0", ready16); end
    n_vec++; if (sclk16 !== 1'b0)  begin n_err++; $display("FAIL reset_sclk: got %b expected 0", sclk16); end
    n_vec++; if (lrck16 !== 1'b0)  begin n_err++; $display("FAIL reset_lrck: got %b expected 0", lrck16); end
    n_vec++; if (sdata16 !== 1'b0) begin n_err++; $display("FAIL reset_sdata: got %b expected 0", sdata16); end
`ifdef I2S_TX_OVERRUN_EN
    n_vec++; if (ovr16 !== 1'b0)   begin n_err++; $display("FAIL reset_overrun: got %b expected 0", ovr16); end
`endif
  endtask

  // Release reset with rate present in the first cycle, then check one frame
  // followed by 1000 idle cycles.
  task automatic test_single_frame();
    logic [63:0] sd_v, lr_v;
    int se, ce, rc, idle_bad, idle_rdy;
    logic o1, o2;
    l16 = 16'hA5C3; r16 = 16'h0F01;
    reset = 1'b1;
    start_frame();
    n_vec++; if (ready16 !== 1'b1) begin n_err++; $display("FAIL single_ready: got %b expected 1", ready16); end
    capture(0, 16'h0, 16'h0, sd_v, lr_v, se, ce, rc, o1, o2);
    n_vec++; if (sd_v !== 64'h52E18000_07808000) begin n_err++; $display("FAIL single_sdata: got %h expected %h", sd_v, 64'h52E18000_07808000); end
    n_vec++; if (lr_v !== 64'h00000000_FFFFFFFF) begin n_err++; $display("FAIL single_lrck: got %h expected %h", lr_v, 64'h00000000_FFFFFFFF); end
    n_vec++; if (se !== 0) begin n_err++; $display("FAIL single_sclk: got %0d bad cycles expected 0", se); end
    n_vec++; if (ce !== 0) begin n_err++; $display("FAIL single_edge: got %0d off-edge changes expected 0", ce); end
    n_vec++; if (rc !== 0) begin n_err++; $display("FAIL single_extra_ready: got %0d expected 0", rc); end
    idle_bad = 0; idle_rdy = 0;
    for (int i = 0; i < 1000; i++) begin
      if (sclk16 !== 1'b0 || lrck16 !== 1'b0 || sdata16 !== 1'b0) idle_bad++;
      if (ready16 !== 1'b0) idle_rdy++;
      step();
    end
    n_vec++; if (idle_bad !== 0) begin n_err++; $display("FAIL idle_outputs: got %0d active cycles expected 0", idle_bad); end
    n_vec++; if (idle_rdy !== 0) begin n_err++; $display("FAIL idle_ready: got %0d pulses expected 0", idle_rdy); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] fl [4];
    logic [15:0] fr [4];
    logic [63:0] sd_v, lr_v, ev;
    int se, ce, rc;
    logic o1, o2;
    fl = '{16'hA5C3, 16'hFFFF, 16'h0001, 16'h1234};
    fr = '{16'h0F01, 16'h8000, 16'h7FFE, 16'hABCD};
    l16 = fl[0]; r16 = fr[0];
    start_frame();
    for (int f = 0; f < 4; f++) begin
      n_vec++; if (ready16 !== 1'b1) begin n_err++; $display("FAIL b2b_ready%0d: got %b expected 1", f, ready16); end
      if (f < 3) capture(FRAME, fl[f+1], fr[f+1], sd_v, lr_v, se, ce, rc, o1, o2);
      else       capture(0, 16'h0, 16'h0, sd_v, lr_v, se, ce, rc, o1, o2);
      ev = exp_vec16(fl[f], fr[f]);
      n_vec++; if (sd_v !== ev) begin n_err++; $display("FAIL b2b_sdata%0d: got %h expected %h", f, sd_v, ev); end
      n_vec++; if (lr_v !== 64'h00000000_FFFFFFFF) begin n_err++; $display("FAIL b2b_lrck%0d: got %h expected %h", f, lr_v, 64'h00000000_FFFFFFFF); end
      n_vec++; if (se !== 0) begin n_err++; $display("FAIL b2b_sclk%0d: got %0d bad cycles expected 0", f, se); end
      n_vec++; if (ce !== 0 || rc !== 0) begin n_err++; $display("FAIL b2b_edge_ready%0d: got %0d/%0d expected 0/0", f, ce, rc); end
    end
    n_vec++; if (sclk16 !== 1'b0 || lrck16 !== 1'b0 || ready16 !== 1'b0) begin n_err++; $display("FAIL b2b_end_idle: got %b%b%b expected 000", sclk16, lrck16, ready16); end
  endtask

  task automatic test_mid_frame_rate();
    logic [63:0] sd_v, lr_v;
    int se, ce, rc;
    logic o100, o101;
    l16 = 16'h1234; r16 = 16'h5678;
    start_frame();
    capture(100, 16'hFFFF, 16'hFFFF, sd_v, lr_v, se, ce, rc, o100, o101);
    n_vec++; if (sd_v !== exp_vec16(16'h1234, 16'h5678)) begin n_err++; $display("FAIL mid_sdata: got %h expected %h", sd_v, exp_vec16(16'h1234, 16'h5678)); end
    n_vec++; if (rc !== 0) begin n_err++; $display("FAIL mid_ready: got %0d pulses expected 0", rc); end
    n_vec++; if (se !== 0) begin n_err++; $display("FAIL mid_sclk: got %0d bad cycles expected 0", se); end
`ifdef I2S_TX_OVERRUN_EN
    n_vec++; if (o100 !== 1'b0) begin n_err++; $display("FAIL mid_overrun_t100: got %b expected 0", o100); end
    n_vec++; if (o101 !== 1'b1) begin n_err++; $display("FAIL mid_overrun_t101: got %b expected 1", o101); end
    n_vec++; if (ovr16 !== 1'b1) begin n_err++; $display("FAIL mid_overrun_sticky: got %b expected 1", ovr16); end
`endif
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    l16 = 16'hA5C3; r16 = 16'h0F01;
    start_frame();
    repeat (243) step();
    // Cycle t+244 lies inside slot 40: sclk high, lrck high, r_data bit 8 = 1.
    n_vec++; if ({sclk16, lrck16, sdata16} !== 3'b111) begin n_err++; $display("FAIL prereset_outputs: got %b expected 111", {sclk16, lrck16, sdata16}); end
    #2 reset = 1'b0;
    #1;
    n_vec++; if ({ready16, sclk16, lrck16, sdata16} !== 4'b0000) begin n_err++; $display("FAIL async_reset: got %b expected 0000", {ready16, sclk16, lrck16, sdata16}); end
`ifdef I2S_TX_OVERRUN_EN
    n_vec++; if (ovr16 !== 1'b0) begin n_err++; $display("FAIL reset_clears_overrun: got %b expected 0", ovr16); end
`endif
    #1 reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if ({ready16, sclk16, lrck16, sdata16} !== 4'b0000) bad++;
    end
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL post_reset_quiet: got %0d active cycles expected 0", bad); end
  endtask

  task automatic test_width();
    logic [63:0] sd_v, lr_v;
    int se, ce, rc;
    logic o1, o2;
    use24 = 1'b1;
    l24 = 24'h800001; r24 = 24'h000000;
    start_frame();
    n_vec++; if (ready24 !== 1'b1) begin n_err++; $display("FAIL w24_ready: got %b expected 1", ready24); end
    capture(0, 16'h0, 16'h0, sd_v, lr_v, se, ce, rc, o1, o2);
    n_vec++; if (sd_v !== 64'h40000080_00000000) begin n_err++; $display("FAIL w24_sdata: got %h expected %h", sd_v, 64'h40000080_00000000); end
    n_vec++; if (se !== 0 || ce !== 0) begin n_err++; $display("FAIL w24_timing: got %0d/%0d expected 0/0", se, ce); end
    use24 = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_mid_frame_rate();
    test_reset_mid_frame();
    test_width();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
